cla_seq_adder: RTL and testbench



---
 rtl/cla_seq_adder.sv | 127 ++++++++++++
 tb/tb_cla_seq_adder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder/subtractor: resolves one SLICE-bit lookahead
// group per clock, LSB slice first, with the inter-slice carry held in a register.
module cla_seq_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             Z
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, s_q, s_next;
    logic [KW-1:0]    k_q;
    logic             carry_q, msb_carry_q, z_q;
    logic             accept, last;

    logic [SLICE-1:0] a_sl, b_sl, g, p, sum_sl;
    logic [SLICE:0]   c_sl;
    logic             term, cy;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (k_q == K_LAST);

    // Lookahead for the current slice: every carry is a flat sum of products of
    // the slice generate/propagate terms and the registered carry-in.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        a_sl   = a_q[int'(k_q)*SLICE +: SLICE];
        b_sl   = b_q[int'(k_q)*SLICE +: SLICE];
        g      = a_sl & b_sl;
        p      = a_sl ^ b_sl;
        c_sl   = '0;
        term   = 1'b0;
        cy     = 1'b0;
        c_sl[0] = carry_q;
        for (int i = 0; i < SLICE; i++) begin
            term = carry_q;
            for (int m = 0; m <= i; m++) term = term & p[m];
            cy = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                cy = cy | term;
            end
            c_sl[i+1] = cy;
        end
        sum_sl = p ^ c_sl[SLICE-1:0];
        s_next = s_q;
        s_next[int'(k_q)*SLICE +: SLICE] = sum_sl;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            s_q         <= '0;
            carry_q     <= 1'b0;
            msb_carry_q <= 1'b0;
            z_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (accept) begin
                    carry_q <= SUB ? 1'b1 : C_in;
                    k_q     <= '0;
                end
                RUN: begin
                    s_q     <= s_next;
                    carry_q <= c_sl[SLICE];
                    if (last) begin
                        msb_carry_q <= c_sl[SLICE-1];
                        z_q         <= (s_next == '0);
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: operand registers carry no reset; they are only read after a load.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= A;
            b_q <= SUB ? ~B : B;
        end
    end

    assign S = s_q;
    assign C = carry_q;
    assign V = carry_q ^ msb_carry_q;
    assign Z = z_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: a 32/4 instance and a WIDTH==SLICE==4 instance
// sharing clock and reset, with hand-computed expected results.
module tb_cla_seq_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c, v, z;
    logic [31:0] a, b, s;

    logic        in_valid4, in_ready4, c_in4, sub4, out_valid4, out_ready4, c4, v4, z4;
    logic [3:0]  a4, b4, s4;

    int n_checks = 0;
    int n_fail   = 0;

    cla_seq_adder #(.WIDTH(32), .SLICE(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .C_in(c_in), .SUB(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(s), .C(c), .V(v), .Z(z)
    );

    cla_seq_adder #(.WIDTH(4), .SLICE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(a4), .B(b4), .C_in(c_in4), .SUB(sub4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .S(s4), .C(c4), .V(v4), .Z(z4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run32(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tc, input logic tsub, input logic [31:0] es,
                         input logic ec, input logic ev, input logic ez);
        int cyc;
        a = ta; b = tb; c_in = tc; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; a = $urandom; b = $urandom; c_in = ~tc; sub = ~tsub;
        check({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'd8);
        check({tag, "_s"}, s, es);
        check({tag, "_cvz"}, {29'b0, c, v, z}, {29'b0, ec, ev, ez});
        tick();
        check({tag, "_release"}, {30'b0, in_ready, out_valid}, 32'd2);
    endtask

    task automatic run4(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                        input logic tc, input logic tsub, input logic [3:0] es,
                        input logic ec, input logic ev, input logic ez);
        int cyc;
        a4 = ta; b4 = tb; c_in4 = tc; sub4 = tsub; in_valid4 = 1'b1; out_ready4 = 1'b1;
        tick();
        in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        cyc = 0;
        while (!out_valid4 && cyc < 10) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'd1);
        check({tag, "_s"}, {28'b0, s4}, {28'b0, es});
        check({tag, "_cvz"}, {29'b0, c4, v4, z4}, {29'b0, ec, ev, ez});
        tick();
    endtask

    initial begin
        int t;
        int seen;

        // Reset held with in_valid asserted and random operands on both instances.
        rst = 1'b0;
        in_valid = 1'b1; a = $urandom; b = $urandom; c_in = 1'b1; sub = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b1; a4 = 4'hA; b4 = 4'h5; c_in4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1;
        tick();
        tick();
        check("rst_hs", {30'b0, in_ready, out_valid}, 32'd2);
        check("rst_s", s, 32'd0);
        check("rst_cvz", {29'b0, c, v, z}, 32'd0);
        check("rst4_hs", {30'b0, in_ready4, out_valid4}, 32'd2);
        rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0;
        tick();
        check("rst_noacc", {30'b0, in_ready, out_valid}, 32'd2);

        // Plain adds, carry ripple, signed overflow.
        run32("add9",    32'h0000_0009, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0009, 1'b0, 1'b0, 1'b0);
        run32("ripple",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run32("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run32("cin_add", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);

        // Subtraction; C_in must be ignored.
        run32("sub5_7",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run32("sub7_5",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run32("sub_c0",  32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run32("ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // Back-pressure in DONE while the inputs churn.
        a = 32'h0F0F_0F0F; b = 32'h0101_0101; c_in = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        check("bp_lat", 32'(t), 32'd8);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid; a = $urandom; b = $urandom; sub = ~sub; c_in = ~c_in;
            tick();
            check("bp_s", s, 32'h1010_1010);
            check("bp_flags", {27'b0, in_ready, out_valid, c, v, z}, 32'b01000);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_release", {30'b0, in_ready, out_valid}, 32'd2);

        // Back-to-back issue with in_valid held high: period N+2.
        a = 32'h0000_0100; b = 32'h0000_0200; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        t = 0;
        while (!in_ready && t < 30) begin
            tick();
            t++;
        end
        check("b2b_idle", 32'(t), 32'd9);
        a = 32'h0000_0010; b = 32'h0000_0020;
        tick();
        t++;
        check("b2b_period", 32'(t), 32'd10);
        check("b2b_acc", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        check("b2b_s", s, 32'h0000_0030);
        tick();

        // Reset while slice k=3 is pending.
        a = 32'h1111_1111; b = 32'h2222_2222; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        check("midrst_hs", {30'b0, in_ready, out_valid}, 32'd2);
        check("midrst_s", s, 32'd0);
        check("midrst_cvz", {29'b0, c, v, z}, 32'd0);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst_noresult", 32'(seen), 32'd0);

        // Single-slice configuration.
        run4("w4_3p3",  4'h3, 4'h3, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0);
        run4("w4_ovf",  4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0);
        run4("w4_wrap", 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        run4("w4_sub",  4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
